// File: rtl/tinyodin_pkg.sv
// Shared types and geometry for the synaptic SRAM scheduler.
// No logic; constants and enums only.
package tinyodin_pkg;

  localparam int N   = 256;
  localparam int M   = 8;
  localparam int WPE = N / 8;
  localparam int WB  = $clog2(WPE);
  localparam int AW  = M + WB;

  typedef enum logic [1:0] {OWN_NONE, OWN_EVT, OWN_OBI} slot_owner_e;
  typedef enum logic {ST_IDLE, ST_RUN} sched_state_e;

endpackage

// File: rtl/synarray_sched.sv
// Shares the synaptic SRAM between the event sequencer (32 word reads per event) and OBI.
// Latency: OBI rvalid 1 cycle after gnt; event word 0 data 2 cycles after evt grant.
// Backpressure: none on syn stream; OBI waits at most OBI_MAX_WAIT lost cycles.
module synarray_sched
  import tinyodin_pkg::*;
#(
  parameter int OBI_MAX_WAIT = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          evt_req_i,
  input  logic [M-1:0]  evt_idx_i,
  output logic          evt_gnt_o,
  output logic          busy_o,
  output logic          syn_valid_o,
  output logic [WB-1:0] syn_word_o,
  output logic [31:0]   syn_data_o,
  output logic          evt_done_o,
  input  logic          obi_req_i,
  input  logic          obi_we_i,
  input  logic [31:0]   obi_addr_i,
  input  logic [31:0]   obi_wdata_i,
  output logic          obi_gnt_o,
  output logic          obi_rvalid_o,
  output logic [31:0]   obi_rdata_o,
  output logic          sram_cs_o,
  output logic          sram_we_o,
  output logic [AW-1:0] sram_addr_o,
  output logic [31:0]   sram_wdata_o,
  input  logic [31:0]   sram_rdata_i
);

  localparam int WCW = $clog2(OBI_MAX_WAIT + 2);
  localparam logic [WCW-1:0] WAIT_LIM = WCW'(OBI_MAX_WAIT);
  localparam logic [WB-1:0]  LAST_WORD = WB'(WPE - 1);

  sched_state_e   state;
  logic [M-1:0]   idx_q;
  logic [WB-1:0]  word_cnt;
  logic [WCW-1:0] wait_cnt;
  slot_owner_e    rsp_owner;
  logic [WB-1:0]  rsp_word;
  logic           rsp_we;

  slot_owner_e    owner;
  logic           obi_win;
  logic           obi_addr_unused;

  // Byte-lane and high address bits alias onto the SRAM word space.
  assign obi_addr_unused = ^{obi_addr_i[31:AW+2], obi_addr_i[1:0]};

  assign obi_win = obi_req_i && (state == ST_IDLE || wait_cnt == WAIT_LIM);

  always_comb begin
    owner = OWN_NONE;
    if (obi_win)               owner = OWN_OBI;
    else if (state == ST_RUN)  owner = OWN_EVT;
  end

  assign evt_gnt_o = (state == ST_IDLE);
  assign busy_o    = (state != ST_IDLE) || (rsp_owner == OWN_EVT);
  assign obi_gnt_o = (owner == OWN_OBI);

  always_comb begin
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    case (owner)
      OWN_EVT: begin
        sram_cs_o   = 1'b1;
        sram_addr_o = {idx_q, word_cnt};
      end
      OWN_OBI: begin
        sram_cs_o    = 1'b1;
        sram_we_o    = obi_we_i;
        sram_addr_o  = obi_addr_i[AW+1:2];
        sram_wdata_o = obi_wdata_i;
      end
      default: ;
    endcase
  end

  assign syn_valid_o  = (rsp_owner == OWN_EVT);
  assign syn_word_o   = syn_valid_o ? rsp_word : '0;
  assign syn_data_o   = syn_valid_o ? sram_rdata_i : '0;
  assign evt_done_o   = syn_valid_o && (rsp_word == LAST_WORD);
  assign obi_rvalid_o = (rsp_owner == OWN_OBI);
  assign obi_rdata_o  = (obi_rvalid_o && !rsp_we) ? sram_rdata_i : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      idx_q     <= '0;
      word_cnt  <= '0;
      wait_cnt  <= '0;
      rsp_owner <= OWN_NONE;
      rsp_word  <= '0;
      rsp_we    <= 1'b0;
    end else begin
      rsp_owner <= owner;
      rsp_word  <= word_cnt;
      rsp_we    <= obi_we_i;

      if (!obi_req_i || obi_win)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_LIM)
        wait_cnt <= wait_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (evt_req_i) begin
            state    <= ST_RUN;
            idx_q    <= evt_idx_i;
            word_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (owner == OWN_EVT) begin
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == LAST_WORD) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_synarray_sched.sv
// Directed bench for synarray_sched with a behavioural 1-cycle-read SRAM.
module tb_synarray_sched;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        evt_req;
  logic [7:0]  evt_idx;
  logic        evt_gnt, busy, syn_valid, syn_done;
  logic [4:0]  syn_word;
  logic [31:0] syn_data;
  logic        obi_req, obi_we, obi_gnt, obi_rvalid;
  logic [31:0] obi_addr, obi_wdata, obi_rdata;
  logic        sram_cs, sram_we;
  logic [12:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  logic        load_en;
  logic [12:0] load_addr;
  logic [31:0] load_data;
  logic [31:0] mem [0:8191];

  int nvec = 0;
  int nerr = 0;

  always #5 CLK = ~CLK;

  synarray_sched #(.OBI_MAX_WAIT(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .evt_req_i(evt_req), .evt_idx_i(evt_idx), .evt_gnt_o(evt_gnt), .busy_o(busy),
    .syn_valid_o(syn_valid), .syn_word_o(syn_word), .syn_data_o(syn_data), .evt_done_o(syn_done),
    .obi_req_i(obi_req), .obi_we_i(obi_we), .obi_addr_i(obi_addr), .obi_wdata_i(obi_wdata),
    .obi_gnt_o(obi_gnt), .obi_rvalid_o(obi_rvalid), .obi_rdata_o(obi_rdata),
    .sram_cs_o(sram_cs), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
  );

  always @(posedge CLK) begin
    if (load_en)
      mem[load_addr] <= load_data;
    else if (sram_cs) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= mem[sram_addr];
    end
  end

  function automatic logic [31:0] exp_word(input logic [7:0] idx, input int w);
    logic [4:0] w5;
    w5 = w[4:0];
    if (idx == 8'd5) return w * 32'h1111_1111;
    return {idx, 3'b000, w5, 16'hC0DE};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one event from request to done, checking the word stream; optionally injects one OBI read.
  task automatic run_event(input logic [7:0] idx, input bit with_obi, input int exp_done);
    int nvalid, nbusy, done_k, gnt_k, lost, exp_w;
    nvalid = 0; nbusy = 0; done_k = -1; gnt_k = -1; lost = 0; exp_w = 0;
    @(posedge CLK); #1;
    evt_req = 1'b1; evt_idx = idx;
    @(negedge CLK);
    chk("evt_gnt", evt_gnt, 1'b1);
    @(posedge CLK); #1;
    evt_req = 1'b0;
    for (int k = 1; k <= 60 && done_k < 0; k++) begin
      @(negedge CLK);
      if (with_obi && k == 4) begin
        obi_req = 1'b1; obi_we = 1'b0; obi_addr = {17'd0, 8'd5, 5'd7, 2'b00};
      end
      if (gnt_k > 0 && k == gnt_k + 1) obi_req = 1'b0;
      #1;
      if (busy) nbusy++;
      if (obi_req) begin
        if (obi_gnt) gnt_k = k;
        else         lost++;
      end
      if (gnt_k > 0 && k == gnt_k + 1) begin
        chk("obi_rvalid_mid_evt", obi_rvalid, 1'b1);
        chk("obi_rdata_mid_evt", obi_rdata, exp_word(8'd5, 7));
      end
      if (syn_valid) begin
        chk("syn_word", syn_word, exp_w[4:0]);
        chk("syn_data", syn_data, exp_word(idx, exp_w));
        chk("evt_done", syn_done, exp_w == 31);
        if (syn_done) done_k = k;
        exp_w++;
        nvalid++;
      end
    end
    chk("done_cycle", done_k, exp_done);
    chk("valid_count", nvalid, 32);
    if (with_obi) begin
      chk("obi_gnt_cycle", gnt_k, 8);
      chk("obi_lost_cycles", lost, 4);
    end else begin
      chk("busy_cycles", nbusy, 33);
    end
    @(negedge CLK);
    chk("busy_after", busy, 1'b0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [12:0] exp_saddr;
    logic [31:0] exp_rdata;
  } obi_vec_t;

  obi_vec_t vt [6];

  initial begin
    int gnt2_k, done2_k, exp_n;
    bit found;
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int gnt2_k, done2_k, exp_n, wrd;
    bit found;
    logic [7:0] eidx;
    logic [7:0] pre [4];
    pre[0] = 8'd1; pre[1] = 8'd2; pre[2] = 8'd3; pre[3] = 8'd5;

    vt[0] = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 13'h040,  32'h0};
    vt[1] = '{1'b0, 32'h0000_0100, 32'h0,         13'h040,  32'hDEAD_BEEF};
    vt[2] = '{1'b0, 32'h0000_8100, 32'h0,         13'h040,  32'hDEAD_BEEF};
    vt[3] = '{1'b1, 32'h0000_7FFC, 32'h1234_5678, 13'h1FFF, 32'h0};
    vt[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         13'h1FFF, 32'h1234_5678};
    vt[5] = '{1'b0, 32'h0000_028C, 32'h0,         13'h0A3,  32'h3333_3333};

    RST_N = 1'b0; evt_req = 1'b0; evt_idx = '0;
    obi_req = 1'b0; obi_we = 1'b0; obi_addr = '0; obi_wdata = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;

    for (int i = 0; i < 4; i++) begin
      for (int w = 0; w < 32; w++) begin
        @(negedge CLK);
        load_en = 1'b1; load_addr = {pre[i], w[4:0]}; load_data = exp_word(pre[i], w);
      end
    end
    @(negedge CLK);
    load_en = 1'b0;

    chk("rst_evt_gnt", evt_gnt, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_syn_valid", syn_valid, 1'b0);
    chk("rst_syn_data", syn_data, 32'h0);
    chk("rst_evt_done", syn_done, 1'b0);
    chk("rst_obi_gnt", obi_gnt, 1'b0);
    chk("rst_obi_rvalid", obi_rvalid, 1'b0);
    chk("rst_sram_cs", sram_cs, 1'b0);
    RST_N = 1'b1;

    run_event(8'd5, 1'b0, 33);
    run_event(8'd5, 1'b1, 34);

    // Back-to-back events with the request held across the first one.
    @(posedge CLK); #1;
    evt_req = 1'b1; evt_idx = 8'd1;
    @(negedge CLK);
    chk("b2b_gnt1", evt_gnt, 1'b1);
    @(posedge CLK); #1;
    evt_idx = 8'd2;
    gnt2_k = -1; done2_k = -1; exp_n = 0;
    for (int k = 1; k <= 100 && done2_k < 0; k++) begin
      @(negedge CLK);
      if (gnt2_k > 0 && k == gnt2_k + 1) evt_req = 1'b0;
      #1;
      if (evt_req && evt_gnt && gnt2_k < 0) gnt2_k = k;
      if (syn_valid) begin
        eidx = (exp_n < 32) ? 8'd1 : 8'd2;
        wrd  = exp_n % 32;
        chk("b2b_word", syn_word, wrd[4:0]);
        chk("b2b_data", syn_data, exp_word(eidx, wrd));
        if (syn_done && exp_n == 63) done2_k = k;
        exp_n++;
      end
    end
    evt_req = 1'b0;
    chk("b2b_gnt2_cycle", gnt2_k, 33);
    chk("b2b_done2_cycle", done2_k, 66);
    chk("b2b_word_count", exp_n, 64);

    // Event and OBI request in the same IDLE cycle.
    @(posedge CLK); #1;
    evt_req = 1'b1; evt_idx = 8'd3;
    obi_req = 1'b1; obi_we = 1'b1; obi_addr = 32'h0; obi_wdata = 32'hCAFE_F00D;
    @(negedge CLK);
    chk("sim_evt_gnt", evt_gnt, 1'b1);
    chk("sim_obi_gnt", obi_gnt, 1'b1);
    chk("sim_sram_we", sram_we, 1'b1);
    chk("sim_sram_wdata", sram_wdata, 32'hCAFE_F00D);
    @(posedge CLK); #1;
    evt_req = 1'b0; obi_req = 1'b0; obi_we = 1'b0;
    @(negedge CLK);
    chk("sim_obi_rvalid", obi_rvalid, 1'b1);
    chk("sim_obi_rdata", obi_rdata, 32'h0);
    chk("sim_evt_w0_cs", sram_cs, 1'b1);
    chk("sim_evt_w0_we", sram_we, 1'b0);
    chk("sim_evt_w0_addr", sram_addr, 13'h060);
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge CLK);
      if (syn_done) found = 1'b1;
    end
    chk("sim_evt_done_seen", found, 1'b1);

    // Reset in the middle of an event.
    @(posedge CLK); #1;
    evt_req = 1'b1; evt_idx = 8'd5;
    @(posedge CLK); #1;
    evt_req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge CLK);
      if (syn_valid && syn_word == 5'd10) found = 1'b1;
    end
    chk("rstmid_word10_seen", found, 1'b1);
    RST_N = 1'b0;
    #1;
    chk("rstmid_syn_valid", syn_valid, 1'b0);
    chk("rstmid_syn_data", syn_data, 32'h0);
    chk("rstmid_done", syn_done, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_cs", sram_cs, 1'b0);
    chk("rstmid_evt_gnt", evt_gnt, 1'b1);
    @(negedge CLK);
    chk("rstmid_hold_done", syn_done, 1'b0);
    RST_N = 1'b1;
    run_event(8'd5, 1'b0, 33);

    // OBI accesses while idle, including address aliasing.
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      obi_req = 1'b1; obi_we = vt[i].we; obi_addr = vt[i].addr; obi_wdata = vt[i].wdata;
      @(negedge CLK);
      chk("tbl_gnt", obi_gnt, 1'b1);
      chk("tbl_cs", sram_cs, 1'b1);
      chk("tbl_we", sram_we, vt[i].we);
      chk("tbl_sram_addr", sram_addr, vt[i].exp_saddr);
      @(posedge CLK); #1;
      obi_req = 1'b0; obi_we = 1'b0;
      @(negedge CLK);
      chk("tbl_rvalid", obi_rvalid, 1'b1);
      chk("tbl_rdata", obi_rdata, vt[i].exp_rdata);
      chk("tbl_no_syn", syn_valid, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
